// File: rtl/reduce_ring_output_port_lookup.sv
// -----------------------------------------------------------------------------
// reduce_ring_output_port_lookup
//
// Output port lookup for a reduce-ring node on the NetFPGA user data path.
// It sits between the input arbiter and the output queues. For each packet it
// rewrites the destination one-hot field of the IOQ module header:
//   - odd source port (CPU queue)  -> destination = NEXT_HOP[15:0]
//   - even source port (MAC)       -> destination = the CPU queue paired with
//                                     that MAC, i.e. 1 << (src + 1)
// The rewrite is applied as the word enters a 4-entry {ctrl,data} FIFO, so
// header and body words leave in order with a minimum latency of one clock.
//
// The block is also a stage on the UDP register ring. Every reg_* signal is
// passed through one register. A request whose reg_addr_in[22:2] matches
// BLOCK_TAG and which nobody has acknowledged yet is answered here.
//   word 0  NEXT_HOP  RW  reset 32'h0000_0004
//   word 1  PKT_CNT   RO  header words rewritten (wraps)
//   word 2  CTRL      RW  bit0 = bypass (forward headers unmodified)
//   word 3  reserved, reads 0
//
// Build option: define OPL_PKT_COUNTER_EN to implement PKT_CNT. Without it
// there is no counter logic and PKT_CNT reads 0.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   in_data/in_ctrl/in_wr      input word; ctrl 0xFF = IOQ header,
//                              other nonzero = module header/EOP mask, 0 = body
//   in_rdy                     input accepted while high (FIFO used <= 2)
//   out_data/out_ctrl/out_wr   output word; out_wr = !empty && out_rdy
//   out_rdy                    downstream can accept
//   reg_*_in / reg_*_out       register ring, in and registered out
// -----------------------------------------------------------------------------
`default_nettype none

module reduce_ring_output_port_lookup #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int          UDP_REG_SRC_WIDTH = 2,
  parameter logic [20:0] BLOCK_TAG         = 21'h2001
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,

  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,

  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [22:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [22:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

  localparam int FIFO_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int DEPTH  = 4;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } parse_state_t;

  // Replace the destination field [63:48] according to the source port in
  // [31:16]. A source so large that src+1 shifts past bit 15 yields no
  // destination at all rather than aliasing onto a low port.
  function automatic logic [DATA_WIDTH-1:0] rewrite_dst(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           hop
  );
    logic [15:0]           src;
    logic [16:0]           shamt;
    logic [15:0]           dst;
    logic [DATA_WIDTH-1:0] res;
    src   = word[31:16];
    shamt = {1'b0, src} + 17'd1;
    if (src[0]) begin
      dst = hop;
    end else if (shamt < 17'd16) begin
      dst = 16'd1 << shamt[3:0];
    end else begin
      dst = '0;
    end
    res        = word;
    res[63:48] = dst;
    return res;
  endfunction

  // Control and configuration state
  parse_state_t         state_q;
  parse_state_t         state_d;
  logic                 is_ioq_hdr;
  logic                 rewrite_en;

  logic [FIFO_W-1:0]    fifo_mem [DEPTH];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           used;
  logic                 push;
  logic                 pop;
  logic [FIFO_W-1:0]    wr_word;

  logic [31:0]          next_hop;
  logic                 bypass;
  logic [31:0]          pkt_cnt;
  logic                 reg_hit;
  logic                 reg_wr_hit;
  logic [31:0]          reg_rd_data;

  // ---------------------------------------------------------------------------
  // Input stage: parse, rewrite and write into the FIFO
  // ---------------------------------------------------------------------------
  // A word offered while the FIFO is completely full is dropped; it neither
  // enters the FIFO nor advances the parser.
  assign push = in_wr && (used != 3'd4);
  assign pop  = out_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_ioq_hdr = 1'b0;
    case (state_q)
      ST_HDR: begin
        is_ioq_hdr = (in_ctrl == '1);
        if (push && (in_ctrl == '0)) begin
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (push && (in_ctrl != '0)) begin
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  assign rewrite_en = is_ioq_hdr && !bypass;
  assign wr_word    = rewrite_en ? {in_ctrl, rewrite_dst(in_data, next_hop[15:0])}
                                 : {in_ctrl, in_data};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   used <= used + 3'd1;
        2'b01:   used <= used - 3'd1;
        default: used <= used;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: FIFO head straight to the output bus
  // ---------------------------------------------------------------------------
  // Headroom of two entries is kept so an upstream that samples in_rdy a
  // cycle late still lands its word in the FIFO.
  assign in_rdy   = (used <= 3'd2);
  assign out_wr   = (used != 3'd0) && out_rdy;
  assign out_ctrl = fifo_mem[rd_ptr][FIFO_W-1:DATA_WIDTH];
  assign out_data = fifo_mem[rd_ptr][DATA_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Register ring stage: local registers and one-clock pass-through
  // ---------------------------------------------------------------------------
  // A request already acknowledged upstream is never claimed again, even if
  // its tag matches.
  assign reg_hit    = reg_req_in && !reg_ack_in && (reg_addr_in[22:2] == BLOCK_TAG);
  assign reg_wr_hit = reg_hit && !reg_rd_wr_L_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_hop <= 32'h0000_0004;
      bypass   <= 1'b0;
    end else if (reg_wr_hit) begin
      case (reg_addr_in[1:0])
        2'd0:    next_hop <= reg_data_in;
        2'd2:    bypass   <= reg_data_in[0];
        default: ;
      endcase
    end
  end

`ifdef OPL_PKT_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (push && rewrite_en) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`else
  assign pkt_cnt = '0;
`endif

  always_comb begin
    reg_rd_data = '0;
    case (reg_addr_in[1:0])
      2'd0:    reg_rd_data = next_hop;
      2'd1:    reg_rd_data = pkt_cnt;
      2'd2:    reg_rd_data = {31'd0, bypass};
      default: reg_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (reg_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_L_in ? reg_rd_data : reg_data_in;
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reduce_ring_output_port_lookup.sv
`timescale 1ns/1ps
module tb_reduce_ring_output_port_lookup;

  localparam logic [20:0] TAG = 21'h2001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b0;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;

  always #5 clk = ~clk;

  reduce_ring_output_port_lookup dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [71:0] exp_q[$];

  // reference model state
  bit          m_in_pkt;
  logic [31:0] m_hop;
  bit          m_bypass;
  logic [31:0] m_cnt;

  bit          rand_rdy = 1'b0;
  bit          rdy_force = 1'b1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      chk("out_wr_needs_rdy", out_rdy, 1'b1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", {out_ctrl, out_data});
      end else begin
        chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reg_inputs();
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic model_reset();
    m_in_pkt = 0; m_hop = 32'h4; m_bypass = 0; m_cnt = 0;
  endtask

  // Expected output word from the forwarding rules.
  task automatic model_word(input logic [7:0] c, input logic [63:0] d, output logic [71:0] w);
    logic [63:0] r;
    int          src;
    logic [15:0] dst;
    r = d;
    if (c == 8'hFF && !m_in_pkt && !m_bypass) begin
      src = int'(d[31:16]);
      if (src % 2 == 1)      dst = m_hop[15:0];
      else if (src + 1 < 16) dst = 16'(1 << (src + 1));
      else                   dst = 16'h0;
      r[63:48] = dst;
      m_cnt = m_cnt + 1;
    end
    if (!m_in_pkt && c == 8'h00)      m_in_pkt = 1;
    else if (m_in_pkt && c != 8'h00)  m_in_pkt = 0;
    w = {c, r};
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] d);
    logic [71:0] w;
    int waited = 0;
    while (!in_rdy && waited < 500) begin
      tick();
      waited++;
    end
    if (!in_rdy) begin
      chk("in_rdy_timeout", in_rdy, 1'b1);
      return;
    end
    model_word(c, d, w);
    exp_q.push_back(w);
    in_ctrl = c; in_data = d; in_wr = 1;
    tick();
    in_wr = 0;
  endtask

  task automatic send_pkt(input logic [15:0] src, input int nbody, input bit ff_eop);
    logic [7:0] eop_c;
    send(8'hFF, {16'($urandom), 16'(nbody + 2), src, 16'((nbody + 2) * 8)});
    for (int i = 0; i < nbody; i++) send(8'h00, {$urandom, $urandom});
    eop_c = ff_eop ? 8'hFF : 8'(1 << $urandom_range(0, 7));
    send(eop_c, {$urandom, $urandom});
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic reg_op(input logic rw_l, input logic ack_i, input logic [22:0] addr,
                        input logic [31:0] wd, input logic [1:0] src,
                        output logic [59:0] outs);
    reg_req_in = 1; reg_ack_in = ack_i; reg_rd_wr_L_in = rw_l;
    reg_addr_in = addr; reg_data_in = wd; reg_src_in = src;
    tick();
    outs = {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
    clear_reg_inputs();
  endtask

  task automatic reg_wr(input logic [1:0] idx, input logic [31:0] d);
    logic [59:0] o;
    reg_op(1'b0, 1'b0, {TAG, idx}, d, 2'd1, o);
    chk("reg_wr_ack", {o[59:57], o[56:34]}, {3'b110, TAG, idx});
    if (idx == 2'd0) m_hop = d;
    if (idx == 2'd2) m_bypass = d[0];
  endtask

  task automatic reg_rd(input logic [1:0] idx, output logic [31:0] d);
    logic [59:0] o;
    reg_op(1'b1, 1'b0, {TAG, idx}, 32'hA5A5_5A5A, 2'd1, o);
    chk("reg_rd_ack", o[59:57], 3'b111);
    d = o[33:2];
  endtask

  initial begin : main
    logic [31:0] rd;
    logic [59:0] o;
    logic [15:0] src;
    in_wr = 0; in_data = '0; in_ctrl = '0;
    model_reset();

    // reset with busy register inputs: outputs must stay cleared
    reg_req_in = 1; reg_ack_in = 1; reg_rd_wr_L_in = 1;
    reg_addr_in = {TAG, 2'd0}; reg_data_in = 32'hFFFF_FFFF; reg_src_in = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_reg_outs", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 60'd0);
    clear_reg_inputs();
    @(posedge clk); #1;
    reset = 0;
    tick();
    chk("idle_in_rdy", in_rdy, 1'b1);
    chk("idle_out_wr", out_wr, 1'b0);
    chk("idle_reg_outs", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 60'd0);

    // CPU source -> reset NEXT_HOP, 1-clk latency
    send(8'hFF, {16'h0000, 16'd3, 16'd1, 16'd24});
    chk("cpu_hdr_latency", out_wr, 1'b1);
    chk("cpu_hdr_dst", out_data[63:48], 16'h0004);
    send(8'h00, 64'h0123_4567_89AB_CDEF);
    send(8'h01, 64'hFEDC_BA98_7654_3210);
    drain();

    // MAC1 source -> paired CPU queue
    send(8'hFF, {16'h0000, 16'd3, 16'd2, 16'd24});
    chk("mac_hdr_dst", out_data[63:48], 16'h0008);
    send(8'h00, 64'h1111_2222_3333_4444);
    send(8'h80, 64'h5555_6666_7777_8888);
    drain();

    // bypass leaves the header alone
    reg_wr(2'd2, 32'h1);
    send(8'hFF, {16'hABCD, 16'd3, 16'd2, 16'd24});
    chk("bypass_hdr_dst", out_data[63:48], 16'hABCD);
    send(8'h00, 64'h1);
    send(8'h01, 64'h2);
    drain();
    reg_wr(2'd2, 32'h0);

    // backpressure: in_rdy drops once three words are queued
    rdy_force = 0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_rdy_open", in_rdy, 1'b1);
      send((i == 0) ? 8'hFF : ((i == 1) ? 8'h00 : 8'h0F), {16'h0, 16'd3, 16'd5, 16'd24} + 64'(i));
    end
    chk("bp_in_rdy_closed", in_rdy, 1'b0);
    repeat (3) begin
      tick();
      chk("bp_out_wr_held", out_wr, 1'b0);
    end
    rdy_force = 1;
    drain();

    // register ring
    reg_wr(2'd0, 32'h10);
    reg_rd(2'd0, rd);
    chk("next_hop_readback", rd, 32'h10);
    reg_op(1'b1, 1'b0, {21'h1234, 2'd0}, 32'hDEAD_BEEF, 2'd2, o);
    chk("miss_passthru", o, {3'b101, 21'h1234, 2'd0, 32'hDEAD_BEEF, 2'd2});
    reg_op(1'b1, 1'b1, {TAG, 2'd0}, 32'h1234_5678, 2'd1, o);
    chk("acked_passthru", o, {3'b111, TAG, 2'd0, 32'h1234_5678, 2'd1});
    reg_op(1'b0, 1'b1, {TAG, 2'd0}, 32'h99, 2'd1, o);
    reg_rd(2'd0, rd);
    chk("acked_write_ignored", rd, 32'h10);
    reg_rd(2'd3, rd);
    chk("reserved_reads_0", rd, 32'h0);
    reg_wr(2'd2, 32'h1);
    reg_rd(2'd2, rd);
    chk("ctrl_readback", rd, 32'h1);
    reg_wr(2'd2, 32'h0);
    tick();
    chk("ring_idle_req", reg_req_out, 1'b0);
    send_pkt(16'd3, 2, 1'b0);
    drain();

    // reset mid-packet
    rdy_force = 0;
    tick(); tick();
    send(8'hFF, {16'h0, 16'd4, 16'd9, 16'd32});
    send(8'h00, 64'h77);
    reset = 1;
    exp_q.delete();
    tick();
    chk("midrst_out_wr", out_wr, 1'b0);
    reset = 0;
    model_reset();
    rdy_force = 1;
    tick();
    chk("midrst_in_rdy", in_rdy, 1'b1);

    // five packets after reset, then counter
    send(8'hFF, {16'h0, 16'd3, 16'd7, 16'd24});
    chk("post_rst_hdr_dst", out_data[63:48], 16'h0004);
    send(8'h00, 64'h3);
    send(8'h02, 64'h4);
    for (int p = 0; p < 4; p++) send_pkt(16'($urandom_range(0, 15)), $urandom_range(1, 3), 1'b0);
    drain();
    reg_rd(2'd1, rd);
`ifdef OPL_PKT_COUNTER_EN
    chk("pkt_cnt_5", rd, 32'd5);
`else
    chk("pkt_cnt_absent", rd, 32'd0);
`endif
    reg_wr(2'd1, 32'hFFFF);
    reg_rd(2'd1, rd);
`ifdef OPL_PKT_COUNTER_EN
    chk("pkt_cnt_ro", rd, 32'd5);
`else
    chk("pkt_cnt_ro", rd, 32'd0);
`endif

    // randomized traffic with random backpressure
    rand_rdy = 1;
    for (int p = 0; p < 60; p++) begin
      if (p % 10 == 0) reg_wr(2'd0, {16'($urandom), 16'($urandom)});
      if (p % 7 == 3)  reg_wr(2'd2, {31'($urandom), ($urandom_range(0, 3) == 0)});
      if ($urandom_range(0, 7) == 0) src = 16'($urandom_range(16, 65535));
      else                           src = 16'($urandom_range(0, 15));
      send_pkt(src, $urandom_range(1, 4), ($urandom_range(0, 5) == 0));
    end
    rand_rdy = 0;
    rdy_force = 1;
    tick();
    drain();
    reg_rd(2'd1, rd);
`ifdef OPL_PKT_COUNTER_EN
    chk("pkt_cnt_final", rd, m_cnt);
`else
    chk("pkt_cnt_final", rd, 32'd0);
`endif
    reg_rd(2'd0, rd);
    chk("next_hop_final", rd, m_hop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
